// File: rtl/ign_timing_monitor.sv
// Ignition timing monitor: measures trigger period, trigger-to-ignition delay and ignition dwell
// in clk cycles. Optional input glitch filter when IGN_MON_GLITCH_FILTER_EN is defined.
module ign_timing_monitor #(
  parameter int unsigned      CNT_W    = 24,
  parameter logic [CNT_W-1:0] TIMEOUT  = 24'd1_000_000,
  parameter int unsigned      FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  input  logic             ign_in,
  input  logic             meas_ready,
  input  logic             ovr_clr,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] delay,
  output logic [CNT_W-1:0] dwell,
  output logic             missed_ign,
  output logic             stall,
  output logic             overrun
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_IGN  = 2'd1;
  localparam logic [1:0] S_IGN_ON    = 2'd2;
  localparam logic [1:0] S_WAIT_TRIG = 2'd3;

  // Bit 0 carries the trigger, bit 1 the ignition; both paths have identical latency.
  logic [1:0] meta, sync, cond, dly, rise_q;
  logic       ign_fall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      // NOTE: flops use non-blocking assignments so each stage samples the pre-edge value.
      meta <= {ign_in, trig_in};
      sync <= meta;
    end
  end

`ifdef IGN_MON_GLITCH_FILTER_EN
  localparam int unsigned FC_W = $clog2(FILT_LEN + 1);

  logic [FC_W-1:0] filt_cnt [2];

  // A filtered level flips only after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cond <= '0;
      // NOTE: this two-entry array is ordinary flops, not RAM, so it is reset with the rest.
      for (int i = 0; i < 2; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == cond[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FC_W'(FILT_LEN - 1)) begin
          cond[i]     <= sync[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  // FILT_LEN only matters when the glitch filter is built.
  localparam int unsigned unused_filt_len = FILT_LEN;

  assign cond = sync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly        <= '0;
      rise_q     <= '0;
      ign_fall_q <= 1'b0;
    end else begin
      dly        <= cond;
      rise_q     <= cond & ~dly;
      ign_fall_q <= ~cond[1] & dly[1];
    end
  end

  logic             trig_rise, ign_rise, ign_fall;
  logic [1:0]       state, nxt_state;
  logic [CNT_W-1:0] cnt, ign_start, d_lat, w_lat, dwell_now;
  logic             publish, timeout_hit, xfer;

  assign trig_rise = rise_q[0];
  assign ign_rise  = rise_q[1];
  assign ign_fall  = ign_fall_q;
  assign dwell_now = cnt - ign_start;
  assign xfer      = meas_valid & meas_ready;

  // Trigger is handled before any coincident ignition edge, which then opens the new cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    nxt_state   = state;
    timeout_hit = 1'b0;
    publish     = trig_rise && (state != S_IDLE);
    if (trig_rise) begin
      if (ign_rise)                          nxt_state = S_IGN_ON;
      else if (state == S_IGN_ON && ign_fall) nxt_state = S_WAIT_TRIG;
      else if (state == S_IGN_ON)            nxt_state = S_IGN_ON;
      else                                   nxt_state = S_WAIT_IGN;
    end else if (state != S_IDLE && cnt == TIMEOUT) begin
      timeout_hit = 1'b1;
      nxt_state   = S_IDLE;
    end else begin
      case (state)
        S_WAIT_IGN: if (ign_rise) nxt_state = S_IGN_ON;
        S_IGN_ON:   if (ign_fall) nxt_state = S_WAIT_TRIG;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ign_start  <= '0;
      d_lat      <= '0;
      w_lat      <= '0;
      meas_valid <= 1'b0;
      period     <= '0;
      delay      <= '0;
      dwell      <= '0;
      missed_ign <= 1'b0;
      stall      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= nxt_state;
      stall <= timeout_hit;

      if (trig_rise)      cnt <= CNT_W'(1);
      else if (cnt != '1) cnt <= cnt + 1'b1;

      if (publish) begin
        period     <= cnt;
        delay      <= d_lat;
        dwell      <= (state == S_IGN_ON) ? dwell_now : w_lat;
        missed_ign <= (state == S_WAIT_IGN);
      end

      // Working registers restart at every trigger; an ignition already high is rebased to 0.
      if (trig_rise) begin
        d_lat     <= '0;
        w_lat     <= '0;
        ign_start <= '0;
      end else if (!timeout_hit) begin
        if (state == S_WAIT_IGN && ign_rise) begin
          d_lat     <= cnt;
          ign_start <= cnt;
        end else if (state == S_IGN_ON && ign_fall) begin
          w_lat <= dwell_now;
        end
      end

      if (publish)   meas_valid <= 1'b1;
      else if (xfer) meas_valid <= 1'b0;

      if (publish && meas_valid && !meas_ready) overrun <= 1'b1;
      else if (ovr_clr)                         overrun <= 1'b0;
    end
  end

endmodule
